// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter slice.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    localparam int unsigned DEF_BUSY_TIMEOUT = 8;
    localparam int unsigned DEF_DONE_TIMEOUT = 64;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after rr_ptr, wrapping.
module i2c_rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Two passes: indices from rr_ptr upward, then the wrapped-around low indices.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!any && req[j] && (j >= 32'(rr_ptr))) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin front end for the single-target I2C write master: grants one
// requester, drives start/addr/data, and tracks m_ready through the transaction.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int unsigned DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          err,
    output logic                        m_start,
    output logic [ADDR_W-1:0]           m_addr,
    output logic [DATA_W-1:0]           m_data,
    input  logic                        m_ready,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned T_MAX = (BUSY_TIMEOUT > DONE_TIMEOUT) ? BUSY_TIMEOUT : DONE_TIMEOUT;
    localparam int unsigned TW    = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0]    BUSY_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0]    DONE_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_req;
    logic               accept;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_inc;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    i2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (win_idx),
        .any    (any_req)
    );

    assign accept    = (state == IDLE) && m_ready && any_req;
    assign req_ready = accept ? grant : '0;
    assign busy      = (state != IDLE);
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            m_start <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            done    <= '0;
            err     <= '0;
            timer   <= '0;
        end else begin
            m_start <= 1'b0;
            done    <= '0;
            err     <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        m_addr  <= sel_addr;
                        m_data  <= sel_data;
                        owner   <= win_idx;
                        rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                        m_start <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                // m_ready is tested before the timeout so a same-cycle change wins.
                WAIT_BUSY: begin
                    if (!m_ready) begin
                        timer <= '0;
                        state <= WAIT_DONE;
                    end else if (timer == BUSY_LAST) begin
                        err[owner] <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                WAIT_DONE: begin
                    if (m_ready) begin
                        done[owner] <= 1'b1;
                        state       <= IDLE;
                    end else if (timer == DONE_LAST) begin
                        err[owner] <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Multi-requester front end for the single-target I2C write master. Up to NUM_REQ clients post 7-bit-address/8-bit-data write requests. The block grants them round-robin, drives the master's start/addr/data inputs, and tracks the master's ready signal through one full transaction. It returns a per-requester done or error pulse and sits between the system-side clients and the I2C master instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- BUSY_TIMEOUT, 8: max cycles after m_start for m_ready to fall
- DONE_TIMEOUT, 64: max cycles in the busy phase for m_ready to return high
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*7  per-requester target address, slice i = [7i+6:7i]
- req_data  in  NUM_REQ*8  per-requester write byte, slice i = [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] && req_ready[i]
- done  out  NUM_REQ  one-cycle pulse to the owner on successful completion
- err  out  NUM_REQ  one-cycle pulse to the owner on timeout
- m_start  out  1  start strobe to master
- m_addr  out  7  address to master, held for the whole transaction
- m_data  out  8  data to master, held for the whole transaction
- m_ready  in  1  master idle indication
- busy  out  1  high in every state except IDLE
- owner  out  $clog2(NUM_REQ)  index of current or last granted requester

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if m_ready=1 and any req_valid, req_ready is combinationally one-hot on the round-robin winner.
  - The search starts at rr_ptr and wraps.
  - In the same cycle: latch addr/data into m_addr/m_data, set owner=winner, set rr_ptr=(winner+1) mod NUM_REQ, go to ISSUE.
  - If m_ready=0 or no req_valid: req_ready=0 and stay.
- ISSUE: m_start=1 for exactly this cycle; clear timer; go to WAIT_BUSY.
- WAIT_BUSY: timer increments every cycle.
  - m_ready=0: clear timer, go to WAIT_DONE.
  - timer reaches BUSY_TIMEOUT-1 with m_ready still 1: pulse err[owner] next cycle, go to IDLE.
- WAIT_DONE: timer increments every cycle.
  - m_ready=1: pulse done[owner] next cycle, go to IDLE.
  - timer reaches DONE_TIMEOUT-1: pulse err[owner], go to IDLE.
- Timer width is $clog2(max(BUSY_TIMEOUT, DONE_TIMEOUT))+1 and saturates; no wrap.
- Requests not granted remain pending; the requester must hold req_valid/addr/data stable until accepted.
- Deasserting req_valid before accept withdraws the request without side effects.
- Only one transaction is in flight. req_ready is 0 in all states but IDLE.

## Timing
- Reset values: m_start=0, m_addr=0, m_data=0, req_ready=0, done=0, err=0, busy=0, owner=0, rr_ptr=0, state=IDLE, timer=0.
- Accept at cycle T → m_start=1 at T+1 → earliest m_ready fall observed at T+3 (master registers start, then its state).
- done/err asserted in the cycle after the terminating condition, for exactly one cycle.
- Back-to-back: the next accept may occur in the cycle done is high, provided m_ready=1.
- m_addr/m_data are stable from T+1 until the next accept.
- Simultaneous requests: the lowest index at or after rr_ptr wins. With all requesters valid continuously, the grant order is 0,1,2,3,0…
- m_ready=0 in IDLE (master busy externally): no grant, no pulses.
- Reset mid-transaction: return to IDLE next cycle with all outputs at reset values. No done/err is issued for the aborted transaction.
- Timeout and m_ready change in the same cycle: the m_ready condition wins.

## Structure
- Package i2c_arb_pkg:
  - state enum (logic [1:0])
  - ADDR_W=7, DATA_W=8
  - default timeout constants
- Sub-module i2c_rr_arbiter: combinational round-robin picker. Inputs req vector and rr_ptr; outputs one-hot grant, index, and any-valid flag.
- The top holds rr_ptr, the FSM, the timer, and the output registers.

## Test plan
- Single request: req 1, addr=0x5A, data=0xC3, with the master model → m_start one pulse at T+1, m_addr=0x5A, m_data=0xC3 held, done[1] once, err=0.
- All four valid continuously for 8 transactions → accepts in order 0,1,2,3,0,1,2,3; exactly one done per accept; busy low only between transactions.
- m_ready stuck at 1 after m_start, BUSY_TIMEOUT=8 → err[owner] pulses 8 cycles after m_start; no done; next request accepted afterwards.
- m_ready stuck at 0 after falling, DONE_TIMEOUT=64 → err[owner] after 64 cycles in WAIT_DONE; state returns to IDLE.
- reset asserted for one cycle during WAIT_DONE → next cycle all outputs at reset values, no done/err; a pending req 2 is granted first (rr_ptr=0 ignoring idle reqs 0,1).
- m_ready held 0 in IDLE with req_valid=4'b1111 → req_ready stays 0, m_start stays 0; grant to requester 0 in the first cycle m_ready=1.
